// File: rtl/button_debounce_pulse.sv
// Push-button front end: pin polarity fix, 2-flop synchronizer, stability-counter debounce.
// Emits one-cycle push / release_pulse strobes and a clean level, DEBOUNCE_CYCLES+3 edges after a clean change.
module button_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic push,
   output logic release_pulse,
   output logic btn_level
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic          btn_in;
   logic          sync_q1;
   logic          btn_s;
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          push_nxt;
   logic          release_nxt;
   logic          level_nxt;

   // Polarity is corrected before the synchronizer so both flops reset to the idle level.
   assign btn_in = btn_raw ^ ACTIVE_LOW;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         btn_s   <= 1'b0;
      end else begin
         sync_q1 <= btn_in;
         btn_s   <= sync_q1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         push          <= 1'b0;
         release_pulse <= 1'b0;
         btn_level     <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         push          <= push_nxt;
         release_pulse <= release_nxt;
         btn_level     <= level_nxt;
      end
   end

   // Counter restarts on every state change, so it can never pass CNT_LAST.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      push_nxt    = (state == PRESS_WAIT)   && (state_nxt == PRESSED);
      release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
      level_nxt   = (state_nxt == PRESSED)  || (state_nxt == RELEASE_WAIT);
   end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: three instances (D=4, D=4 active-low, D=1) against a run-length model.
module tb_button_debounce_pulse;

   logic clk = 1'b0;
   logic rst_n;
   logic raw [3];
   logic push_o [3];
   logic rel_o [3];
   logic lvl_o [3];

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   localparam int DD [3] = '{4, 4, 1};
   localparam bit AL [3] = '{1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_debounce_pulse #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .btn_raw(raw[0]),
      .push(push_o[0]), .release_pulse(rel_o[0]), .btn_level(lvl_o[0]));
   button_debounce_pulse #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .btn_raw(raw[1]),
      .push(push_o[1]), .release_pulse(rel_o[1]), .btn_level(lvl_o[1]));
   button_debounce_pulse #(.DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .btn_raw(raw[2]),
      .push(push_o[2]), .release_pulse(rel_o[2]), .btn_level(lvl_o[2]));

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
      end
   endtask

   // Model: the level flips once the synchronized pin has disagreed with it for D+1 consecutive samples.
   bit m_s1 [3], m_s2 [3], m_lvl [3], m_push [3], m_rel [3];
   int m_run [3];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_push[i] = 0; m_rel[i] = 0; m_run[i] = 0;
         end else begin
            m_push[i] = 0;
            m_rel[i]  = 0;
            if (m_s2[i] != m_lvl[i]) m_run[i] = m_run[i] + 1;
            else                     m_run[i] = 0;
            if (m_run[i] == DD[i] + 1) begin
               m_lvl[i] = !m_lvl[i];
               if (m_lvl[i]) m_push[i] = 1;
               else          m_rel[i]  = 1;
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i] ^ AL[i];
         end
      end
   end

   int push_cnt [3] = '{0, 0, 0};
   int rel_cnt [3]  = '{0, 0, 0};
   int last_push [3] = '{-1, -1, -1};
   int last_rel [3]  = '{-1, -1, -1};
   bit prev_pulse [3] = '{0, 0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d push", i), int'(push_o[i]), int'(m_push[i]));
         chk($sformatf("u%0d release_pulse", i), int'(rel_o[i]), int'(m_rel[i]));
         chk($sformatf("u%0d btn_level", i), int'(lvl_o[i]), int'(m_lvl[i]));
         chk($sformatf("u%0d push&release overlap", i), int'(push_o[i] && rel_o[i]), 0);
         chk($sformatf("u%0d back-to-back pulses", i),
             int'(prev_pulse[i] && (push_o[i] || rel_o[i])), 0);
         prev_pulse[i] = push_o[i] || rel_o[i];
         if (push_o[i] === 1'b1) begin push_cnt[i]++; last_push[i] = cyc; end
         if (rel_o[i]  === 1'b1) begin rel_cnt[i]++;  last_rel[i]  = cyc; end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int t, t2, p, r;
      rst_n = 1'b0;
      raw[0] = 1'b0; raw[1] = 1'b1; raw[2] = 1'b0;
      tick(3);
      chk("reset push", int'(push_o[0]), 0);
      chk("reset release_pulse", int'(rel_o[0]), 0);
      chk("reset btn_level", int'(lvl_o[0]), 0);
      chk("reset u1 btn_level", int'(lvl_o[1]), 0);
      rst_n = 1'b1;
      tick(5);

      // 1: clean press, long hold
      t = cyc; raw[0] = 1'b1;
      tick(40);
      chk("s1 push count", push_cnt[0], 1);
      chk("s1 push cycle", last_push[0], t + 7);
      chk("s1 no release", rel_cnt[0], 0);
      chk("s1 level held", int'(lvl_o[0]), 1);
      t = cyc; raw[0] = 1'b0;
      tick(20);
      chk("s1 release count", rel_cnt[0], 1);
      chk("s1 release cycle", last_rel[0], t + 7);

      // 2: bouncing press 1,0,1,0 every 2 cycles, then stable 1
      p = push_cnt[0];
      for (int k = 0; k < 4; k++) begin
         raw[0] = (k % 2 == 0);
         tick(2);
      end
      chk("s2 no push while bouncing", push_cnt[0], p);
      t = cyc; raw[0] = 1'b1;
      tick(30);
      chk("s2 push count", push_cnt[0], p + 1);
      chk("s2 push cycle", last_push[0], t + 7);

      // 3: bouncing release
      raw[0] = 1'b0; tick(2);
      raw[0] = 1'b1; tick(2);
      chk("s3 level through bounce", int'(lvl_o[0]), 1);
      t = cyc; raw[0] = 1'b0;
      tick(20);
      chk("s3 release count", rel_cnt[0], 2);
      chk("s3 release cycle", last_rel[0], t + 7);
      chk("s3 no extra push", push_cnt[0], p + 1);

      // 4: active-low instance
      t = cyc; raw[1] = 1'b0;
      tick(20);
      t2 = cyc; raw[1] = 1'b1;
      tick(20);
      chk("s4 push count", push_cnt[1], 1);
      chk("s4 push cycle", last_push[1], t + 7);
      chk("s4 release count", rel_cnt[1], 1);
      chk("s4 release cycle", last_rel[1], t2 + 7);

      // 5: reset pulse during PRESS_WAIT with cnt=2
      p = push_cnt[0];
      raw[0] = 1'b1;
      tick(5);
      rst_n = 1'b0;
      #1;
      chk("s5 level in reset", int'(lvl_o[0]), 0);
      chk("s5 push in reset", int'(push_o[0]), 0);
      tick(1);
      rst_n = 1'b1; r = cyc;
      tick(15);
      chk("s5 single push after reset", push_cnt[0], p + 1);
      chk("s5 push cycle", last_push[0], r + 7);
      raw[0] = 1'b0;
      tick(15);

      // 6: DEBOUNCE_CYCLES=1, three press/release cycles
      for (int k = 0; k < 3; k++) begin
         t = cyc; raw[2] = 1'b1;
         tick(8);
         chk($sformatf("s6 push cycle %0d", k), last_push[2], t + 4);
         t = cyc; raw[2] = 1'b0;
         tick(8);
         chk($sformatf("s6 release cycle %0d", k), last_rel[2], t + 4);
      end
      chk("s6 push count", push_cnt[2], 3);
      chk("s6 release count", rel_cnt[2], 3);
      raw[2] = 1'b1; tick(1);
      raw[2] = 1'b0; tick(10);
      chk("s6 one-sample glitch ignored", push_cnt[2], 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Front-end conditioning stage for the push-button path. Sits directly upstream of the LED toggle FSM and drives its push input.
- Takes a raw, asynchronous, bouncing button pin and synchronizes it into the clk domain.
- Debounces it with a stability counter.
- Emits exactly one single-cycle push pulse per debounced press, plus a release pulse and a clean debounced level.

Parameters:
- DEBOUNCE_CYCLES, 2000000: number of consecutive stable clk cycles required to accept a level change (10 ms at 200 MHz). Legal range ≥1.
- ACTIVE_LOW, 0: 1 means the raw pin reads 0 when pressed. The pin is inverted before synchronization.

Ports:
- clk  input  1  system clock (single-ended, post-IBUFDS)
- rst_n  input  1  asynchronous reset, active-low
- btn_raw  input  1  raw button pin, asynchronous to clk
- push  output  1  one-cycle pulse per debounced press; feeds the LED toggle FSM push input
- release_pulse  output  1  one-cycle pulse per debounced release
- btn_level  output  1  debounced button state, 1 = pressed

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0 and resume on the first clk rising edge after deassertion.
- Reset values:
  - push=0, release_pulse=0, btn_level=0.
  - Both synchronizer flops = 0 (idle level after polarity correction).
  - State = IDLE, counter = 0.
- Polarity: btn_in = btn_raw XOR ACTIVE_LOW.
- Synchronizer: btn_in passes through a 2-flop chain. btn_s is the second flop output. No logic between the flops.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). It never wraps; it saturates by construction because it resets on every state change.
- FSM states and transitions (evaluated on each clk rising edge, btn_s sampled):
  - IDLE (btn_level=0):
    - btn_s=1 -> PRESS_WAIT, cnt<=0.
    - Otherwise stay.
  - PRESS_WAIT (btn_level=0):
    - btn_s=0 -> IDLE. Bounce rejected, no pulse.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, push<=1.
    - Else cnt<=cnt+1.
  - PRESSED (btn_level=1):
    - btn_s=0 -> RELEASE_WAIT, cnt<=0.
    - Otherwise stay.
  - RELEASE_WAIT (btn_level=1):
    - btn_s=1 -> PRESSED. Bounce rejected, no pulse, no second push.
    - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse<=1.
    - Else cnt<=cnt+1.
- Output registers:
  - push and release_pulse are registered and default to 0 every cycle unless set as above. Each is exactly 1 cycle wide.
  - btn_level is registered: 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Latency:
  - btn_raw pressed and held clean from edge 0 -> push high in the cycle after edge DEBOUNCE_CYCLES+3. This is 2 sync edges, 1 IDLE->PRESS_WAIT edge, and DEBOUNCE_CYCLES counting edges.
  - btn_level rises in the same cycle as push.
  - Release is symmetric: release_pulse and btn_level=0 arrive DEBOUNCE_CYCLES+3 edges after a clean release.
- Boundary conditions:
  - Glitch shorter than DEBOUNCE_CYCLES consecutive samples: no output change.
  - Any single opposite sample restarts qualification from IDLE/PRESSED with cnt=0.
  - push and release_pulse are never high in the same cycle. They are never high in consecutive cycles for DEBOUNCE_CYCLES ≥ 1.
  - Holding the button indefinitely produces exactly one push (no auto-repeat).
  - Reset asserted mid-qualification or while pressed: outputs drop to 0 asynchronously and no pulse is emitted. If the button is still held after rst_n deasserts, it is treated as a fresh press and push fires DEBOUNCE_CYCLES+3 edges later.
  - DEBOUNCE_CYCLES=1: PRESS_WAIT lasts one cycle; push at edge 4.

Test Plan:
1. DEBOUNCE_CYCLES=4, ACTIVE_LOW=0. Reset, then btn_raw 0->1 at edge 0, held 40 cycles -> push=1 for exactly one cycle after edge 7, btn_level=1 from edge 7 on, release_pulse never asserts.
2. Same config, btn_raw toggles 1,0,1,0,1 every 2 cycles, then stays 1 -> no push during bouncing. Single push exactly 7 edges after the last 0->1 transition (sync + 4-cycle qualification).
3. Pressed and stable, then btn_raw 1->0 with a 2-cycle bounce back to 1, then clean 0 -> btn_level stays 1 through the bounce. release_pulse fires once, 7 edges after the final clean 0. No extra push when the bounce returns to 1.
4. ACTIVE_LOW=1, btn_raw idle=1, pressed=0 for 20 cycles, then 1 -> one push and one release_pulse with the same 7-edge latencies as scenario 1.
5. rst_n pulsed low for 1 cycle during PRESS_WAIT (cnt=2), then btn_raw held 1 -> outputs 0 during reset, no pulse from the aborted qualification, push fires 7 edges after rst_n deasserts.
6. DEBOUNCE_CYCLES=1, clean press -> push at edge 4. Three clean press/release cycles -> exactly 3 push and 3 release_pulse, never overlapping.
